// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU: default widths,
// the reset PC and the fetch-stage state encoding.
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W   = 8;
   localparam int unsigned CPU_DATA_W   = 16;
   localparam int unsigned CPU_RESET_PC = 0;

   typedef enum logic [1:0] {
      FETCH_IDLE   = 2'd0,
      FETCH_REQ    = 2'd1,
      FETCH_HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Clear/enable up-counter that bounds how long a fetch waits for mem_ack.
// tc is high while the count sits at TIMEOUT-1, i.e. on the last allowed
// waiting cycle.
module fetch_timer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins over enable, otherwise hold.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the request/ack handshake with
// instruction memory and hands each fetched word to the IR with a one-cycle
// ins_valid pulse. A fetch that waits TIMEOUT cycles without an ack is
// abandoned with a one-cycle fetch_err pulse. halt is sticky until reset.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W   = CPU_ADDR_W,
   parameter int unsigned DATA_W   = CPU_DATA_W,
   parameter int unsigned RESET_PC = CPU_RESET_PC,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_go,
   input  logic              pc_ld,
   input  logic [ADDR_W-1:0] pc_ld_val,
   input  logic              halt,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ins,
   output logic              ins_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              halted,
   output logic              fetch_err
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ins_q, ins_d;
   logic              ins_valid_q, ins_valid_d;
   logic              fetch_err_q, fetch_err_d;
   logic              halt_pend_q, halt_pend_d;
   logic              timer_clr;
   logic              timer_en;
   logic              timer_tc;

   // The timer sits at zero outside REQ and counts each REQ cycle without an ack.
   assign timer_clr = (state_q != FETCH_REQ);
   assign timer_en  = (state_q == FETCH_REQ) && !mem_ack && !timer_tc;

   fetch_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_fetch_timer (
      .clk (clk),
      .rst (rst),
      .clr (timer_clr),
      .en  (timer_en),
      .tc  (timer_tc)
   );

   // Next-state, PC, instruction latch and pulse generation.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ins_d       = ins_q;
      ins_valid_d = 1'b0;
      fetch_err_d = 1'b0;
      halt_pend_d = halt_pend_q;
      unique case (state_q)
         FETCH_IDLE: begin
            if (halt) begin
               state_d = FETCH_HALTED;
            end else begin
               // A simultaneous load and go fetches from the loaded target.
               if (pc_ld) begin
                  pc_d = pc_ld_val;
               end
               if (fetch_go) begin
                  state_d = FETCH_REQ;
               end
            end
         end
         FETCH_REQ: begin
            // A halt during a fetch waits until that fetch completes or aborts.
            halt_pend_d = halt_pend_q | halt;
            if (mem_ack) begin
               ins_d       = mem_rdata;
               ins_valid_d = 1'b1;
               pc_d        = pc_q + ADDR_W'(1);
               state_d     = (halt_pend_q || halt) ? FETCH_HALTED : FETCH_IDLE;
            end else if (timer_tc) begin
               fetch_err_d = 1'b1;
               state_d     = (halt_pend_q || halt) ? FETCH_HALTED : FETCH_IDLE;
            end
         end
         FETCH_HALTED: begin
            state_d = FETCH_HALTED;
         end
         default: begin
            state_d = FETCH_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: ins is a single word register, not a memory, so it is reset to a known zero.
      if (!rst) begin
         state_q     <= FETCH_IDLE;
         pc_q        <= ADDR_W'(RESET_PC);
         ins_q       <= '0;
         ins_valid_q <= 1'b0;
         fetch_err_q <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ins_q       <= ins_d;
         ins_valid_q <= ins_valid_d;
         fetch_err_q <= fetch_err_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   // Handshake and status outputs decode state directly so reset drops them at once.
   assign mem_req   = (state_q == FETCH_REQ);
   assign busy      = (state_q == FETCH_REQ);
   assign halted    = (state_q == FETCH_HALTED);
   assign mem_addr  = pc_q;
   assign pc_out    = pc_q;
   assign ins       = ins_q;
   assign ins_valid = ins_valid_q;
   assign fetch_err = fetch_err_q;

endmodule
